// File: rtl/sdrc_user_responder_if.sv
// User-side SDRAM controller bus (sdrc_*), shared by traffic masters and the RAM-backed responder.
interface sdrc_user_responder_if;
  logic        I_sdrc_selfrefresh;
  logic        I_sdrc_power_down;
  logic        I_sdrc_wr_n;
  logic        I_sdrc_rd_n;
  logic [20:0] I_sdrc_addr;
  logic [31:0] I_sdrc_data;
  logic [7:0]  I_sdrc_data_len;
  logic [3:0]  I_sdrc_dqm;
  logic        O_sdrc_init_done;
  logic        O_sdrc_busy_n;
  logic        O_sdrc_wrd_ack;
  logic        O_sdrc_rd_valid;
  logic [31:0] O_sdrc_data;

  modport slave (
    input  I_sdrc_selfrefresh, I_sdrc_power_down, I_sdrc_wr_n, I_sdrc_rd_n,
           I_sdrc_addr, I_sdrc_data, I_sdrc_data_len, I_sdrc_dqm,
    output O_sdrc_init_done, O_sdrc_busy_n, O_sdrc_wrd_ack, O_sdrc_rd_valid, O_sdrc_data
  );

  modport master (
    output I_sdrc_selfrefresh, I_sdrc_power_down, I_sdrc_wr_n, I_sdrc_rd_n,
           I_sdrc_addr, I_sdrc_data, I_sdrc_data_len, I_sdrc_dqm,
    input  O_sdrc_init_done, O_sdrc_busy_n, O_sdrc_wrd_ack, O_sdrc_rd_valid, O_sdrc_data
  );
endinterface

// File: rtl/sdrc_user_responder.sv
// Cycle-accurate SDRAM-controller user-bus responder backed by on-chip RAM.
// Define SDRC_RESP_REFRESH_EN to emulate periodic idle refresh busy windows.
module sdrc_user_responder #(
  parameter int unsigned MEM_AW         = 12,
  parameter int unsigned INIT_CYCLES    = 200,
  parameter int unsigned WR_DATA_DLY    = 1,
  parameter int unsigned RD_LAT         = 4,
  parameter int unsigned RECOVER_CYCLES = 3,
  parameter int unsigned REFRESH_PERIOD = 780,
  parameter int unsigned REFRESH_CYCLES = 8
) (
  input  logic                I_sdrc_clk,
  input  logic                I_sdrc_rst_n,
  sdrc_user_responder_if.slave bus
);

  if (WR_DATA_DLY == 0 || RD_LAT < 2 || RECOVER_CYCLES == 0 || INIT_CYCLES == 0 ||
      REFRESH_PERIOD == 0 || REFRESH_CYCLES == 0 || MEM_AW > 21) begin : g_bad_cfg
    $error("sdrc_user_responder: unsupported parameter set");
  end

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_WR_WAIT, ST_WR_BURST, ST_RD_WAIT, ST_RD_BURST, ST_RECOVER,
`ifdef SDRC_RESP_REFRESH_EN
    ST_REFRESH,
`endif
    ST_LOWPWR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [8:0]  beat_q, beat_d;
  logic [12:0] br_q, br_d;
  logic [7:0]  col_q, col_d;
  logic [7:0]  len_q, len_d;
  logic        ack_d;
  logic        req_wr, req_rd, lp_req;
  logic        wr_beat, rd_issue;
  logic [MEM_AW-1:0] mem_idx;
  logic [31:0] mem [2**MEM_AW];

  assign req_wr  = !bus.I_sdrc_wr_n;
  assign req_rd  = !bus.I_sdrc_rd_n;
  assign lp_req  = bus.I_sdrc_selfrefresh || bus.I_sdrc_power_down;
  assign mem_idx = MEM_AW'({br_q, col_q});
  assign wr_beat = (state_q == ST_WR_BURST);
  // Read burst keeps one extra cycle so RECOVER starts after the last output beat.
  assign rd_issue = (state_q == ST_RD_BURST) && (beat_q <= {1'b0, len_q});

`ifdef SDRC_RESP_REFRESH_EN
  logic [15:0] ref_cnt_q;
  logic        ref_pend_q;

  always_ff @(posedge I_sdrc_clk) begin
    if (!I_sdrc_rst_n) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
    end else if (ref_cnt_q == 16'(REFRESH_PERIOD - 1)) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b1;
    end else begin
      ref_cnt_q <= ref_cnt_q + 16'd1;
      if (state_q == ST_IDLE) ref_pend_q <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    br_d    = br_q;
    col_d   = col_q;
    len_d   = len_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == 16'(INIT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_IDLE: begin
`ifdef SDRC_RESP_REFRESH_EN
        if (ref_pend_q) begin
          state_d = ST_REFRESH;
          cnt_d   = 16'(REFRESH_CYCLES - 1);
        end else
`endif
        if (req_wr || req_rd) begin
          ack_d  = 1'b1;
          br_d   = bus.I_sdrc_addr[20:8];
          col_d  = bus.I_sdrc_addr[7:0];
          len_d  = bus.I_sdrc_data_len;
          beat_d = '0;
          if (req_wr) begin
            state_d = (WR_DATA_DLY > 1) ? ST_WR_WAIT : ST_WR_BURST;
            cnt_d   = 16'(WR_DATA_DLY - 2);
          end else begin
            state_d = (RD_LAT > 2) ? ST_RD_WAIT : ST_RD_BURST;
            cnt_d   = 16'(RD_LAT - 3);
          end
        end else if (lp_req) begin
          state_d = ST_LOWPWR;
        end
      end
      ST_WR_WAIT, ST_RD_WAIT: begin
        if (cnt_q == '0) state_d = (state_q == ST_WR_WAIT) ? ST_WR_BURST : ST_RD_BURST;
        else             cnt_d   = cnt_q - 16'd1;
      end
      ST_WR_BURST: begin
        beat_d = beat_q + 9'd1;
        col_d  = col_q + 8'd1;
        if (beat_q[7:0] == len_q) begin
          state_d = ST_RECOVER;
          cnt_d   = 16'(RECOVER_CYCLES - 1);
        end
      end
      ST_RD_BURST: begin
        beat_d = beat_q + 9'd1;
        col_d  = col_q + 8'd1;
        if (beat_q == {1'b0, len_q} + 9'd1) begin
          state_d = ST_RECOVER;
          cnt_d   = 16'(RECOVER_CYCLES - 1);
        end
      end
`ifdef SDRC_RESP_REFRESH_EN
      ST_RECOVER, ST_REFRESH: begin
`else
      ST_RECOVER: begin
`endif
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 16'd1;
      end
      ST_LOWPWR: if (!lp_req) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_sdrc_clk) begin
    if (!I_sdrc_rst_n) begin
      state_q              <= ST_INIT;
      cnt_q                <= '0;
      beat_q               <= '0;
      br_q                 <= '0;
      col_q                <= '0;
      len_q                <= '0;
      bus.O_sdrc_wrd_ack   <= 1'b0;
      bus.O_sdrc_busy_n    <= 1'b0;
      bus.O_sdrc_init_done <= 1'b0;
    end else begin
      state_q              <= state_d;
      cnt_q                <= cnt_d;
      beat_q               <= beat_d;
      br_q                 <= br_d;
      col_q                <= col_d;
      len_q                <= len_d;
      bus.O_sdrc_wrd_ack   <= ack_d;
      bus.O_sdrc_busy_n    <= (state_d == ST_IDLE);
      bus.O_sdrc_init_done <= bus.O_sdrc_init_done || (state_d == ST_IDLE);
    end
  end

  // RAM is never cleared; the reset term only blocks writes of an aborted burst.
  always_ff @(posedge I_sdrc_clk) begin
    if (I_sdrc_rst_n && wr_beat) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (!bus.I_sdrc_dqm[b]) mem[mem_idx][8*b +: 8] <= bus.I_sdrc_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge I_sdrc_clk) begin
    if (!I_sdrc_rst_n) begin
      bus.O_sdrc_rd_valid <= 1'b0;
      bus.O_sdrc_data     <= '0;
    end else begin
      bus.O_sdrc_rd_valid <= rd_issue;
      if (rd_issue) bus.O_sdrc_data <= mem[mem_idx];
    end
  end

endmodule
